// File: rtl/apb_mem_bridge_pkg.sv
// Shared definitions for the APB-to-memory bridge: FSM state encoding and default widths.
package apb_mem_bridge_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 16;
    localparam int unsigned DEF_DATA_WIDTH     = 16;
    localparam int unsigned DEF_APB_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/apb_byte_merge.sv
// Combinational byte-lane merge: strobed lanes take new data, the rest keep old data.
module apb_byte_merge #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged_c
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    always_comb begin
        merged_c = old_data;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                merged_c[i*8 +: 8] = new_data[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/apb_mem_bridge.sv
// APB completer driving a single-port memory with 1-cycle registered read;
// adds read wait states, does read-modify-write for partial strobes, flags bad addresses.
module apb_mem_bridge
    import apb_mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned APB_ADDR_WIDTH = DEF_APB_ADDR_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_psel,
    input  logic                      i_penable,
    input  logic                      i_pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0]     i_pwdata,
    input  logic [DATA_WIDTH/8-1:0]   i_pstrb,
    output logic [DATA_WIDTH-1:0]     o_prdata,
    output logic                      o_pready,
    output logic                      o_pslverr,
    output logic                      o_mem_en,
    output logic                      o_mem_wr,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_data_w,
    input  logic [DATA_WIDTH-1:0]     i_mem_data_r
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    state_t                  state_q, state_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0]   prdata_d;
    logic                    pready_d, pslverr_d;
    logic                    mem_en_d, mem_wr_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_data_d;
    logic                    addr_err_c;
    logic [DATA_WIDTH-1:0]   merged_c;

    apb_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .old_data (i_mem_data_r),
        .new_data (wdata_q),
        .strb     (pstrb_q),
        .merged_c (merged_c)
    );

    // Misaligned byte offset or address bits beyond the memory depth
    assign addr_err_c = ((i_paddr & APB_ADDR_WIDTH'(NB - 1)) != '0) ||
                        ((i_paddr >> (ADDR_WIDTH + OFF_W)) != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            pwrite_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pstrb_q      <= '0;
            o_prdata     <= '0;
            o_pready     <= 1'b0;
            o_pslverr    <= 1'b0;
            o_mem_en     <= 1'b0;
            o_mem_wr     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_data_w <= '0;
        end else begin
            state_q      <= state_d;
            pwrite_q     <= pwrite_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pstrb_q      <= pstrb_d;
            o_prdata     <= prdata_d;
            o_pready     <= pready_d;
            o_pslverr    <= pslverr_d;
            o_mem_en     <= mem_en_d;
            o_mem_wr     <= mem_wr_d;
            o_mem_addr   <= mem_addr_d;
            o_mem_data_w <= mem_data_d;
        end
    end

    // Next state, next latched request, and outputs decoded from the next state
    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pstrb_d  = pstrb_q;
        prdata_d = o_prdata;

        case (state_q)
            ST_IDLE: begin
                if (i_psel && !i_penable) begin
                    pwrite_d = i_pwrite;
                    addr_d   = ADDR_WIDTH'(i_paddr >> OFF_W);
                    wdata_d  = i_pwdata;
                    pstrb_d  = i_pstrb;
                    if (addr_err_c) begin
                        state_d = ST_ERR;
                    end else if (!i_pwrite) begin
                        state_d = ST_RD_REQ;
                    end else if (&i_pstrb) begin
                        state_d = ST_WR;
                    end else if (i_pstrb == '0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ:  state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (pwrite_q) begin
                    wdata_d = merged_c;
                    state_d = ST_WR;
                end else begin
                    prdata_d = i_mem_data_r;
                    state_d  = ST_RESP;
                end
            end
            ST_WR:      state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            ST_ERR:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        mem_en_d   = (state_d == ST_RD_REQ) || (state_d == ST_WR);
        mem_wr_d   = (state_d == ST_WR);
        mem_addr_d = mem_en_d ? addr_d : '0;
        mem_data_d = mem_wr_d ? wdata_d : '0;
        pready_d   = (state_d == ST_RESP) || (state_d == ST_ERR);
        pslverr_d  = (state_d == ST_ERR);
    end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Scoreboard bench for apb_mem_bridge with a behavioural 1-cycle-read memory.
module tb_apb_mem_bridge;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_psel = 1'b0;
    logic        i_penable = 1'b0;
    logic        i_pwrite = 1'b0;
    logic [31:0] i_paddr = '0;
    logic [15:0] i_pwdata = '0;
    logic [1:0]  i_pstrb = '0;
    logic [15:0] o_prdata;
    logic        o_pready;
    logic        o_pslverr;
    logic        o_mem_en;
    logic        o_mem_wr;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_data_w;
    logic [15:0] i_mem_data_r = '0;

    apb_mem_bridge dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_psel       (i_psel),
        .i_penable    (i_penable),
        .i_pwrite     (i_pwrite),
        .i_paddr      (i_paddr),
        .i_pwdata     (i_pwdata),
        .i_pstrb      (i_pstrb),
        .o_prdata     (o_prdata),
        .o_pready     (o_pready),
        .o_pslverr    (o_pslverr),
        .o_mem_en     (o_mem_en),
        .o_mem_wr     (o_mem_wr),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data_w (o_mem_data_w),
        .i_mem_data_r (i_mem_data_r)
    );

    always #5 i_clk = ~i_clk;

    logic [15:0] mem [0:65535];
    initial for (int k = 0; k < 65536; k++) mem[k] = 16'(k);

    always @(posedge i_clk) begin
        if (o_mem_en) begin
            if (o_mem_wr) mem[o_mem_addr] <= o_mem_data_w;
            else          i_mem_data_r    <= mem[o_mem_addr];
        end
    end

    typedef struct {
        string       name;
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          en_cnt;
        logic [15:0] addr;
        int          start;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          en_seen = 0;
    logic [15:0] model_prdata = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: memory-port address checks and response scoreboard
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            en_seen = 0;
        end else begin
            if (o_mem_en) begin
                en_seen++;
                if (q.size() > 0) check({q[0].name, " mem_addr"}, 32'(o_mem_addr), 32'(q[0].addr));
                else check("unexpected mem_en", 32'(o_mem_en), 32'd0);
            end
            if (o_pready) begin
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check({e.name, " pslverr"}, 32'(o_pslverr), 32'(e.err));
                    check({e.name, " prdata"},  32'(o_prdata),  32'(e.rdata));
                    check({e.name, " latency"}, 32'(cyc - e.start), 32'(e.lat));
                    check({e.name, " mem_en cycles"}, 32'(en_seen), 32'(e.en_cnt));
                end else begin
                    check("unexpected pready", 32'(o_pready), 32'd0);
                end
                en_seen = 0;
            end
        end
    end

    // One APB transfer; called just after a rising edge, returns just after one
    task automatic apb_xfer(input string name, input logic wr, input logic [31:0] addr,
                            input logic [15:0] wdata, input logic [1:0] strb,
                            input logic err, input int lat, input int en_cnt,
                            input logic [15:0] rd_exp);
        exp_t e;
        bit   got;
        if (!wr && !err) model_prdata = rd_exp;
        e.name = name; e.rdata = model_prdata; e.err = err; e.lat = lat;
        e.en_cnt = en_cnt; e.addr = addr[16:1]; e.start = cyc;
        q.push_back(e);
        i_psel = 1'b1; i_penable = 1'b0; i_pwrite = wr;
        i_paddr = addr; i_pwdata = wdata; i_pstrb = strb;
        @(posedge i_clk); #1;
        i_penable = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge i_clk);
            if (o_pready) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL %s timeout: no pready within 20 cycles", name);
            if (q.size() > 0) void'(q.pop_front());
        end
        @(posedge i_clk); #1;
        i_psel = 1'b0; i_penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pready"},     32'(o_pready), 32'd0);
        check({tag, " pslverr"},    32'(o_pslverr), 32'd0);
        check({tag, " mem_en"},     32'(o_mem_en), 32'd0);
        check({tag, " mem_wr"},     32'(o_mem_wr), 32'd0);
        check({tag, " mem_addr"},   32'(o_mem_addr), 32'd0);
        check({tag, " mem_data_w"}, 32'(o_mem_data_w), 32'd0);
        check({tag, " prdata"},     32'(o_prdata), 32'd0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge i_clk); i_rst_n = 1'b1;
        idle(2);

        //        name          wr   addr           wdata     strb   err lat en  read value
        apb_xfer("rd 0x10",     0, 32'h0000_0010, 16'h0000, 2'b00, 0, 3, 1, 16'h0008);
        idle(1);
        apb_xfer("wr full",     1, 32'h0000_0020, 16'hBEEF, 2'b11, 0, 2, 1, 16'h0000);
        apb_xfer("rd back",     0, 32'h0000_0020, 16'h0000, 2'b00, 0, 3, 1, 16'hBEEF);
        idle(1);
        apb_xfer("rmw lo",      1, 32'h0000_0020, 16'h1234, 2'b01, 0, 4, 2, 16'h0000);
        apb_xfer("rd rmw lo",   0, 32'h0000_0020, 16'h0000, 2'b00, 0, 3, 1, 16'hBE34);
        apb_xfer("rmw hi",      1, 32'h0000_0002, 16'hABCD, 2'b10, 0, 4, 2, 16'h0000);
        apb_xfer("rd rmw hi",   0, 32'h0000_0002, 16'h0000, 2'b00, 0, 3, 1, 16'hAB01);
        idle(2);
        apb_xfer("misaligned",  0, 32'h0000_0011, 16'h0000, 2'b00, 1, 1, 0, 16'h0000);
        apb_xfer("out of range",1, 32'h0002_0000, 16'hDEAD, 2'b11, 1, 1, 0, 16'h0000);
        idle(1);
        apb_xfer("wr zero strb",1, 32'h0000_0000, 16'hFFFF, 2'b00, 0, 1, 0, 16'h0000);
        apb_xfer("rd addr 0",   0, 32'h0000_0000, 16'h0000, 2'b00, 0, 3, 1, 16'h0000);
        idle(2);

        // Reset asserted while an RMW sits in RD_DATA
        begin
            exp_t e;
            e.name = "rmw cut"; e.rdata = model_prdata; e.err = 1'b0; e.lat = 4;
            e.en_cnt = 2; e.addr = 16'h0020; e.start = cyc;
            q.push_back(e);
            i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b1;
            i_paddr = 32'h0000_0040; i_pwdata = 16'hFFFF; i_pstrb = 2'b01;
            @(posedge i_clk); #1;
            i_penable = 1'b1;
            @(posedge i_clk); #1;
            i_rst_n = 1'b0;
            #1;
            check_all_zero("async reset");
            i_psel = 1'b0; i_penable = 1'b0;
            q.delete();
            model_prdata = '0;
            repeat (2) @(posedge i_clk);
            @(negedge i_clk); i_rst_n = 1'b1;
            idle(1);
        end
        apb_xfer("rd after cut",0, 32'h0000_0040, 16'h0000, 2'b00, 0, 3, 1, 16'h0020);
        idle(2);

        check("scoreboard drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
